// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: valid/ready pipeline stage carrying pc+inst, with a stall-cycle counter.
// Define PIPE_STAGE_SKID_EN to add a skid entry so that up_ready comes straight from a register.
module pipe_stage_buf #(
   parameter int PC_W   = 32,
   parameter int INST_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              up_valid,
   output logic              up_ready,
   input  logic [PC_W-1:0]   up_pc,
   input  logic [INST_W-1:0] up_inst,
   output logic              dn_valid,
   input  logic              dn_ready,
   output logic [PC_W-1:0]   dn_pc,
   output logic [INST_W-1:0] dn_inst,
   output logic [CNT_W-1:0]  stall_cnt
);
   localparam int E = 1 + PC_W + INST_W;
   // An entry is {valid, pc, inst}; an empty entry is all-zero, which gives the zero bubble.
   logic [E-1:0] main_q, main_d, up_e;
   logic main_v, up_x, dn_x;
   assign up_e     = {1'b1, up_pc, up_inst};
   assign main_v   = main_q[E-1];
   assign dn_valid = main_v;
   assign dn_pc    = main_q[E-2 -: PC_W];
   assign dn_inst  = main_q[INST_W-1:0];
   assign up_x     = up_valid & up_ready;
   assign dn_x     = main_v & dn_ready;
`ifdef PIPE_STAGE_SKID_EN
   logic [E-1:0] skid_q, skid_d;
   logic skid_v, rdy_q;
   assign skid_v   = skid_q[E-1];
   assign up_ready = rdy_q;
   // up_ready is low whenever skid is full, so up_x never coincides with skid_v.
   always_comb begin
      main_d = dn_x ? (skid_v ? skid_q : up_x ? up_e : '0) : (up_x & ~main_v) ? up_e : main_q;
      skid_d = dn_x ? '0 : (up_x & main_v) ? up_e : skid_q;
   end
   always_ff @(posedge clk) begin
      if (rst | flush) begin
         main_q <= '0;
         skid_q <= '0;
         rdy_q  <= 1'b1;
      end else begin
         main_q <= main_d;
         skid_q <= skid_d;
         rdy_q  <= ~skid_d[E-1];
      end
   end
`else
   assign up_ready = ~main_v | dn_ready;
   always_comb main_d = up_x ? up_e : dn_x ? '0 : main_q;
   always_ff @(posedge clk) begin
      if (rst | flush) main_q <= '0;
      else main_q <= main_d;
   end
`endif
   always_ff @(posedge clk) begin
      if (rst) stall_cnt <= '0;
      else if (main_v & ~dn_ready & ~flush & (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
   end
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed and random stimulus checked against a queue model of the stage.
module tb_pipe_stage_buf;
   logic clk = 1'b0, rst = 1'b0, flush = 1'b0, up_valid = 1'b0, dn_ready = 1'b0;
   logic [31:0] up_pc = '0, up_inst = '0;
   logic up_ready, dn_valid, up_ready4, dn_valid4;
   logic [31:0] dn_pc, dn_inst, dn_pc4, dn_inst4;
   logic [15:0] stall_cnt;
   logic [3:0] stall_cnt4;
   int n_chk = 0, n_fail = 0;
   logic [63:0] q[$];
   int cnt = 0, cnt4 = 0;
   logic exp_rdy;

   always #5 clk = ~clk;

   pipe_stage_buf dut (
      .clk(clk), .rst(rst), .flush(flush), .up_valid(up_valid), .up_ready(up_ready),
      .up_pc(up_pc), .up_inst(up_inst), .dn_valid(dn_valid), .dn_ready(dn_ready),
      .dn_pc(dn_pc), .dn_inst(dn_inst), .stall_cnt(stall_cnt)
   );
   pipe_stage_buf #(.CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .flush(flush), .up_valid(up_valid), .up_ready(up_ready4),
      .up_pc(up_pc), .up_inst(up_inst), .dn_valid(dn_valid4), .dn_ready(dn_ready),
      .dn_pc(dn_pc4), .dn_inst(dn_inst4), .stall_cnt(stall_cnt4)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: apply inputs, check up_ready before the edge, advance the model, check outputs after.
   task automatic cyc(input logic r, input logic f, input logic uv, input logic dr,
                      input logic [31:0] pc, input logic [31:0] inst);
      logic [63:0] hd;
      rst = r; flush = f; up_valid = uv; dn_ready = dr; up_pc = pc; up_inst = inst;
`ifdef PIPE_STAGE_SKID_EN
      exp_rdy = q.size() < 2;
`else
      exp_rdy = (q.size() == 0) || dr;
`endif
      #1;
      if (!r) chk("up_ready", up_ready, exp_rdy);
      @(posedge clk);
      if (r || f) q.delete();
      else begin
         if (q.size() > 0 && !dr) begin
            if (cnt < 65535) cnt++;
            if (cnt4 < 15) cnt4++;
         end
         if (q.size() > 0 && dr) void'(q.pop_front());
         if (uv && exp_rdy) q.push_back({pc, inst});
      end
      if (r) begin cnt = 0; cnt4 = 0; end
      #1;
      hd = (q.size() > 0) ? q[0] : 64'd0;
      chk("dn_valid", dn_valid, q.size() > 0);
      chk("dn_pc", dn_pc, hd[63:32]);
      chk("dn_inst", dn_inst, hd[31:0]);
      chk("stall_cnt", stall_cnt, cnt);
      chk("stall_cnt4", stall_cnt4, cnt4);
   endtask

   initial begin
      cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 0, 1, 1, 32'h55, 32'h66);
      chk("rst_dn_valid", dn_valid, 0);
      chk("rst_up_ready", up_ready, 1);
      // single transfer, one-cycle latency
      cyc(0, 0, 1, 1, 32'h100, 32'h24010005);
      chk("req030_pc", dn_pc, 32'h100);
      chk("req030_inst", dn_inst, 32'h24010005);
      // back-to-back stream
      for (int i = 0; i < 4; i++) cyc(0, 0, 1, 1, i * 4, 32'hA000 + i);
      chk("stream_last_pc", dn_pc, 32'hC);
      cyc(0, 0, 0, 1, 0, 0);
      chk("stream_drain", dn_valid, 0);
      // stall with a second entry offered
      cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 32'h200, 32'h1);
      for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 32'h204, 32'h2);
      chk("hold_pc", dn_pc, 32'h200);
      chk("hold_cnt", stall_cnt, 5);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 0);
      // flush with entries held and a same-cycle offer
      cyc(0, 0, 1, 0, 32'h280, 32'h3);
      cyc(0, 0, 1, 0, 32'h284, 32'h4);
      cyc(0, 1, 1, 0, 32'h300, 32'h5);
      chk("flush_valid", dn_valid, 0);
      chk("flush_pc", dn_pc, 0);
      cyc(0, 0, 0, 1, 0, 0);
      // reset while valid and offered
      cyc(0, 0, 1, 0, 32'h400, 32'h6);
      cyc(1, 0, 1, 0, 32'h404, 32'h7);
      chk("rst_mid_valid", dn_valid, 0);
      chk("rst_mid_cnt", stall_cnt, 0);
      // saturation of the 4-bit counter
      cyc(0, 0, 1, 0, 32'h500, 32'h8);
      for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0, 0);
      chk("sat_cnt4", stall_cnt4, 15);
      chk("sat_cnt16", stall_cnt, 20);
      cyc(0, 0, 0, 1, 0, 0);
      // random traffic
      for (int i = 0; i < 400; i++)
         cyc($urandom_range(63) == 0, $urandom_range(15) == 0, $urandom_range(2) != 0,
             $urandom_range(2) != 0, $urandom, $urandom);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 The block SHALL have parameter PC_W, default 32, giving the width of the carried instruction address.
REQ-002 The block SHALL have parameter INST_W, default 32, giving the width of the carried instruction word.
REQ-003 The block SHALL have parameter CNT_W, default 16, giving the width of the stall-cycle counter.
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 flush  input  1  discard all held entries and any same-cycle upstream transfer.
REQ-007 up_valid  input  1  upstream offers an entry.
REQ-008 up_ready  output  1  stage accepts an entry this cycle.
REQ-009 up_pc  input  PC_W  upstream instruction address.
REQ-010 up_inst  input  INST_W  upstream instruction word.
REQ-011 dn_valid  output  1  stage presents an entry downstream.
REQ-012 dn_ready  input  1  downstream consumes the presented entry this cycle.
REQ-013 dn_pc  output  PC_W  presented instruction address.
REQ-014 dn_inst  output  INST_W  presented instruction word.
REQ-015 stall_cnt  output  CNT_W  count of cycles with dn_valid=1 and dn_ready=0.

Function
REQ-016 An upstream transfer SHALL occur when up_valid=1 and up_ready=1 on a rising edge; a downstream transfer SHALL occur when dn_valid=1 and dn_ready=1.
REQ-017 The block SHALL hold a main entry (valid bit, pc, inst) that drives dn_valid/dn_pc/dn_inst directly from registers; latency from upstream transfer to dn_valid=1 SHALL be exactly one cycle when the stage is empty.
REQ-018 Whenever dn_valid=0, dn_pc and dn_inst SHALL both read all-zero (bubble = zero word).
REQ-019 Entries SHALL leave in acceptance order; no entry SHALL be duplicated or dropped except by flush or reset.
REQ-020 Simultaneous downstream and upstream transfer on a full main entry SHALL replace the main entry with the new one, with dn_valid remaining 1.
REQ-021 flush=1 SHALL, on that edge, clear all valid bits, zero all held data, and ignore up_valid; priority: rst > flush > transfers.
REQ-022 flush SHALL NOT alter stall_cnt.
REQ-023 stall_cnt SHALL increment by 1 on each edge where dn_valid=1, dn_ready=0 and flush=0, and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-024 A held entry with dn_ready=0 SHALL keep dn_pc/dn_inst stable until its downstream transfer or a flush.

Reset
REQ-025 On rst=1 at a rising edge: all valid bits=0, dn_pc=0, dn_inst=0, stall_cnt=0; up_ready SHALL be 1 in the cycle after reset.
REQ-026 rst asserted mid-transfer SHALL discard the in-flight entry with no partial update of any field.

Configuration
REQ-027 Macro PIPE_STAGE_SKID_EN defined: the block SHALL add one skid entry; up_ready SHALL be a register output equal to NOT skid-valid; an upstream transfer while main is valid and dn_ready=0 SHALL go to the skid entry; on a downstream transfer with skid valid, skid SHALL move to main and skid SHALL clear; up_ready SHALL depend on no input combinationally.
REQ-028 Macro PIPE_STAGE_SKID_EN undefined: no skid entry; up_ready SHALL equal (NOT main-valid) OR dn_ready combinationally.
REQ-029 In both builds REQ-016..REQ-026 SHALL hold unchanged.

Verification
REQ-030 Reset then up_valid=1, pc=0x100, inst=0x24010005, dn_ready=1 -> next cycle dn_valid=1, dn_pc=0x100, dn_inst=0x24010005.
REQ-031 Stream pc 0x0,0x4,0x8,0xC with dn_ready=1 -> dn_pc 0x0,0x4,0x8,0xC on consecutive cycles, no gaps.
REQ-032 Hold dn_ready=0 for 5 cycles with main=0x200 -> dn_pc stays 0x200, stall_cnt=5; skid build: second entry 0x204 accepted, then up_ready=0 until dn_ready=1, after which 0x200 then 0x204 emerge.
REQ-033 flush=1 with main and skid valid and up_valid=1 pc=0x300 -> next cycle dn_valid=0, dn_pc=0, dn_inst=0, 0x300 never appears, stall_cnt unchanged.
REQ-034 CNT_W=4, dn_ready=0 for 20 cycles with valid entry -> stall_cnt=15 and holds.
REQ-035 rst=1 while dn_valid=1 and up_valid=1 -> next cycle all outputs zero, up_ready=1.
